dbus_slave_mem: RTL

Data-bus responder: the slave end of the CPU data-bus request/acknowledge handshake. It accepts one CPU load or store at a time, waits a fixed programmable latency, then commits the store or returns the load data. Each completion is signalled with a single-cycle acknowledge. It serves as the backing data memory for testbenches and as the reference slave behaviour for the future bus-interface unit.

---
 rtl/dbus_if.sv | 25 ++
 rtl/dbus_slave_mem.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dbus_if.sv
// CPU data-bus request/acknowledge handshake bundle shared by the CPU-side
// master and the data-bus responder.
interface dbus_if #(
  parameter int DBUS_AW   = 32,
  parameter int DBUS_DW   = 32,
  parameter int DBUS_ISEL = 4
);
  logic                 req_m2dbiu;
  logic [DBUS_AW-1:0]   adr_m2dbiu;
  logic [DBUS_DW-1:0]   dat_m2dbiu;
  logic                 we_m2dbiu;
  logic [DBUS_ISEL-1:0] sel_m2dbiu;
  logic [DBUS_DW-1:0]   dat_dbiu2m;
  logic                 ack_dbiu2m;

  modport master (
    output req_m2dbiu, adr_m2dbiu, dat_m2dbiu, we_m2dbiu, sel_m2dbiu,
    input  dat_dbiu2m, ack_dbiu2m
  );

  modport slave (
    input  req_m2dbiu, adr_m2dbiu, dat_m2dbiu, we_m2dbiu, sel_m2dbiu,
    output dat_dbiu2m, ack_dbiu2m
  );
endinterface

// File: rtl/dbus_slave_mem.sv
// Data-bus responder: one load/store at a time, fixed LATENCY, single-cycle
// registered acknowledge, byte-lane stores into a word-addressed memory.
module dbus_slave_mem #(
  parameter int DBUS_AW   = 32,
  parameter int DBUS_DW   = 32,
  parameter int DBUS_ISEL = 4,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  dbus_if.slave bus_io
);

  localparam int IW  = $clog2(DEPTH);
  localparam int OFS = $clog2(DBUS_ISEL);
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        adr_q;
  logic [DBUS_DW-1:0]   dat_q;
  logic                 we_q;
  logic [DBUS_ISEL-1:0] sel_q;
  logic [DBUS_DW-1:0]   rdat_q;
  logic                 ack_q;
  logic                 run_q;
  logic [DBUS_DW-1:0]   mem_q [DEPTH];

  logic                 capture_s;
  logic                 enter_ack_s;
  logic [IW-1:0]        eff_idx_s;
  logic [DBUS_DW-1:0]   eff_dat_s;
  logic                 eff_we_s;
  logic [DBUS_ISEL-1:0] eff_sel_s;
  logic                 unused_adr_s;

  assign unused_adr_s = ^bus_io.adr_m2dbiu;

  // Next-state and latency-counter logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        // run_q keeps the release edge of an asynchronous reset from accepting
        if (bus_io.req_m2dbiu && run_q) begin
          capture_s = 1'b1;
          cnt_d     = LAT_M1;
          state_d   = (LATENCY == 1) ? S_ACK : S_WAIT;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_ACK;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // With LATENCY=1 the commit edge is also the capture edge, so take live inputs
  always_comb begin
    enter_ack_s = (state_d == S_ACK) && (state_q != S_ACK);
    if (capture_s) begin
      eff_idx_s = bus_io.adr_m2dbiu[OFS +: IW];
      eff_dat_s = bus_io.dat_m2dbiu;
      eff_we_s  = bus_io.we_m2dbiu;
      eff_sel_s = bus_io.sel_m2dbiu;
    end else begin
      eff_idx_s = adr_q;
      eff_dat_s = dat_q;
      eff_we_s  = we_q;
      eff_sel_s = sel_q;
    end
  end

  // FSM, capture registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_ack_s;
      if (capture_s) begin
        adr_q <= bus_io.adr_m2dbiu[OFS +: IW];
        dat_q <= bus_io.dat_m2dbiu;
        we_q  <= bus_io.we_m2dbiu;
        sel_q <= bus_io.sel_m2dbiu;
      end
      if (enter_ack_s && !eff_we_s) begin
        rdat_q <= mem_q[eff_idx_s];
      end
    end
  end

  // Memory array is deliberately not reset; writes only on the ACK-entry edge
  always_ff @(posedge clk) begin
    if (enter_ack_s && eff_we_s) begin
      for (int i = 0; i < DBUS_ISEL; i++) begin
        if (eff_sel_s[i]) begin
          mem_q[eff_idx_s][8*i +: 8] <= eff_dat_s[8*i +: 8];
        end
      end
    end
  end

  assign bus_io.dat_dbiu2m = rdat_q;
  assign bus_io.ack_dbiu2m = ack_q;

endmodule
